// File: rtl/dma_pkg.sv
// dma_pkg: shared types for the DMA descriptor path.
//   t_dma_descriptor   : descriptor word handed to the DMA engine
//   t_arb_state        : descriptor arbiter FSM states
//   DMA_ARB_NUM_CH_MAX : largest supported number of descriptor queues
package dma_pkg;

  localparam int DMA_ARB_NUM_CH_MAX = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT_DONE
  } t_arb_state;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
    logic [7:0]  ctrl;
  } t_dma_descriptor;

endpackage

// File: rtl/dma_rr_pick.sv
// dma_rr_pick: combinational rotating-priority picker.
//   req     : request vector, one bit per channel
//   last    : index granted last time; scanning starts at last+1 with wrap
//   gnt_idx : chosen channel (0 when nothing requested)
//   gnt_vld : at least one request present
module dma_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [IW-1:0] idx;

  // Walk the ring from farthest to nearest so the nearest requester
  // after 'last' is the final write and therefore wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % N);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_desc_arbiter.sv
// dma_desc_arbiter: shares one DMA engine between NUM_CH descriptor queues.
// Looks like a single descriptor FIFO to the engine (not_empty/rdack/desc).
// Round-robin grant, per-channel stop mask, one descriptor in flight at a
// time (hold until eng_done), completion watchdog with sticky error.
//
// Optional build macro DMA_ARB_STATS_EN adds per-channel grant/stall
// counters exported on the 'stats' port ({stall,grant} per channel).
//
// Ports:
//   clk, reset_n      clock, async active-low reset
//   ch_not_empty/desc per-queue descriptor available / head descriptor
//   ch_rd_en          one-hot pop pulse to the granted queue
//   ch_stop           stop mask, stopped queues never granted
//   eng_not_empty/rdack/desc  engine FIFO face
//   eng_done          engine finished current descriptor
//   active_ch, arb_busy       granted channel, FSM not idle
//   timeout_err/ch, err_clr   watchdog sticky error, channel, clear
module dma_desc_arbiter
  import dma_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DESC_W      = $bits(t_dma_descriptor),
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_CH-1:0]          ch_not_empty,
  input  logic [NUM_CH*DESC_W-1:0]   ch_desc,
  output logic [NUM_CH-1:0]          ch_rd_en,
  input  logic [NUM_CH-1:0]          ch_stop,
  output logic                       eng_not_empty,
  input  logic                       eng_rdack,
  output logic [DESC_W-1:0]          eng_desc,
  input  logic                       eng_done,
  output logic [$clog2(NUM_CH)-1:0]  active_ch,
  output logic                       arb_busy,
  output logic                       timeout_err,
  output logic [$clog2(NUM_CH)-1:0]  timeout_ch,
  input  logic                       err_clr
`ifdef DMA_ARB_STATS_EN
  ,output logic [NUM_CH*64-1:0]      stats
`endif
);

  localparam int IW   = $clog2(NUM_CH);
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  t_arb_state        state;
  logic [IW-1:0]     last_grant;
  logic [WD_W-1:0]   wd_cnt;
  logic [NUM_CH-1:0] eligible;
  logic [IW-1:0]     pick_idx;
  logic              pick_vld;
  logic [DESC_W-1:0] desc_arr [NUM_CH];

  assign eligible = ch_not_empty & ~ch_stop;
  assign arb_busy = (state != ARB_IDLE);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_desc
    assign desc_arr[g] = ch_desc[g*DESC_W +: DESC_W];
  end

  dma_rr_pick #(.N(NUM_CH), .IW(IW)) u_pick (
    .req     (eligible),
    .last    (last_grant),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  // Pop must land in the same cycle the engine acks, so it is decoded
  // straight from state rather than registered.
  assign ch_rd_en = (state == ARB_ISSUE && eng_rdack) ? (NUM_CH'(1) << active_ch) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ARB_IDLE;
      last_grant    <= IW'(NUM_CH - 1);
      active_ch     <= '0;
      eng_not_empty <= 1'b0;
      eng_desc      <= '0;
      timeout_err   <= 1'b0;
      timeout_ch    <= '0;
      wd_cnt        <= '0;
    end else begin
      // Clear first so a same-cycle watchdog set below overrides it.
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (pick_vld) begin
            active_ch     <= pick_idx;
            eng_desc      <= desc_arr[pick_idx];
            eng_not_empty <= 1'b1;
            state         <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          // rdack takes priority over a simultaneous withdraw.
          if (eng_rdack) begin
            last_grant    <= active_ch;
            wd_cnt        <= '0;
            eng_not_empty <= 1'b0;
            state         <= ARB_WAIT_DONE;
          end else if (!eligible[active_ch]) begin
            // Withdrawn: last_grant untouched, so rotation is not consumed.
            eng_not_empty <= 1'b0;
            state         <= ARB_IDLE;
          end
        end
        ARB_WAIT_DONE: begin
          if (eng_done) begin
            state <= ARB_IDLE;
          end else if (TIMEOUT_CYC != 0 && wd_cnt == WD_LAST) begin
            timeout_err <= 1'b1;
            timeout_ch  <= active_ch;
            state       <= ARB_IDLE;
          end else if (wd_cnt != '1) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state         <= ARB_IDLE;
          eng_not_empty <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMA_ARB_STATS_EN
  for (genvar g = 0; g < NUM_CH; g++) begin : g_stats
    logic [31:0] grant_cnt;
    logic [31:0] stall_cnt;
    logic        owns;

    // A channel is "granted" while it holds the engine (ISSUE or WAIT_DONE).
    assign owns = (state != ARB_IDLE) && (active_ch == IW'(g));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        grant_cnt <= '0;
        stall_cnt <= '0;
      end else if (err_clr) begin
        grant_cnt <= '0;
        stall_cnt <= '0;
      end else begin
        if (ch_rd_en[g])          grant_cnt <= grant_cnt + 32'd1;
        if (eligible[g] && !owns) stall_cnt <= stall_cnt + 32'd1;
      end
    end

    assign stats[g*64 +: 64] = {stall_cnt, grant_cnt};
  end
`endif

endmodule
